// File: rtl/cmp16_seq_if.sv
// cmp16_seq_if: operand/result handshake bundle for cmp16_seq.
//   in_valid/in_ready  : operand handshake (a, b, signed_cmp qualified by in_valid)
//   out_valid/out_ready: result handshake (out = {gt, eq, lt})
//   master modport     : the producer of operands / consumer of results
//   slave modport      : the comparator
interface cmp16_seq_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_cmp;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out;

   modport master (
      output in_valid, a, b, signed_cmp, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, a, b, signed_cmp, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/cmp16_seq.sv
// cmp16_seq: sequential magnitude comparator, one SLICE-bit slice per cycle,
// scanning MSB-first and stopping at the first unequal slice.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cmp16_seq_if slave modport (operand and result handshakes)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | in_ready high, waiting for operands
// ST_CMP  | comparing slice idx_q of ra_q/rb_q, one slice per cycle
// ST_DONE | out_valid high, out held until out_ready
module cmp16_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic         clk,
   input logic         rst_n,
   cmp16_seq_if.slave  bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  ra_q, rb_q;
   logic [WIDTH-1:0]  ra_d, rb_d;
   logic [IDXW-1:0]   idx_q;
   logic [2:0]        out_q;
   logic              out_valid_q;
   logic              in_ready_q;
   logic [SLICE-1:0]  slice_a, slice_b;

   // Flipping the sign bit of both operands maps two's-complement order onto
   // unsigned order, so the slice engine only ever does unsigned compares.
   always_comb begin
      ra_d = bus.a;
      rb_d = bus.b;
      if (bus.signed_cmp) begin
         ra_d[WIDTH-1] = ~bus.a[WIDTH-1];
         rb_d[WIDTH-1] = ~bus.b[WIDTH-1];
      end
   end

   assign slice_a = ra_q[idx_q*SLICE +: SLICE];
   assign slice_b = rb_q[idx_q*SLICE +: SLICE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ra_q        <= '0;
         rb_q        <= '0;
         idx_q       <= IDX_TOP;
         out_q       <= 3'b000;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  ra_q       <= ra_d;
                  rb_q       <= rb_d;
                  idx_q      <= IDX_TOP;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_CMP;
               end
            end
            ST_CMP: begin
               if (slice_a != slice_b) begin
                  out_q       <= (slice_a > slice_b) ? 3'b100 : 3'b001;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else if (idx_q == '0) begin
                  out_q       <= 3'b010;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  idx_q <= idx_q - IDXW'(1);
               end
            end
            ST_DONE: begin
               // out_q is intentionally left alone so the last result persists.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_cmp16_seq.sv
// tb_cmp16_seq: self-checking bench for cmp16_seq with directed scenarios and
// a randomized regression against a plain-arithmetic reference compare.
module tb_cmp16_seq;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   cmp16_seq_if #(.WIDTH(16)) bus ();

   cmp16_seq #(.WIDTH(16), .SLICE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                          input bit s);
      if (x == y) return 3'b010;
      if (s) return ($signed(x) > $signed(y)) ? 3'b100 : 3'b001;
      return (x > y) ? 3'b100 : 3'b001;
   endfunction

   function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
      for (int i = 3; i >= 0; i--)
         if (x[i*4 +: 4] != y[i*4 +: 4]) return 4 - i;
      return 4;
   endfunction

   // Runs one full transaction; must be entered just after a falling edge and
   // returns just after a falling edge, so back-to-back calls accept at H+1.
   task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input bit sg,
                          input int stall, input bit early,
                          output logic [2:0] got, output int lat,
                          output bit idle_ok, output bit busy_ok,
                          output bit stable_ok, output bit post_ok);
      idle_ok   = (bus.in_ready === 1'b1);
      busy_ok   = 1'b1;
      stable_ok = 1'b1;
      post_ok   = 1'b1;
      bus.a          = ta;
      bus.b          = tb_v;
      bus.signed_cmp = sg;
      bus.in_valid   = 1'b1;
      bus.out_ready  = early;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.a          = 16'($urandom);
      bus.b          = 16'($urandom);
      bus.signed_cmp = 1'($urandom);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      got = bus.out;
      if (!early) begin
         for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
            if (bus.out !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
               stable_ok = 1'b0;
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== got)
         post_ok = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.signed_cmp = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      end
      n_cmp++;
      if (bus.out !== 3'b000) begin
         n_fail++; $display("FAIL reset_out got=%b exp=000", bus.out);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic [15:0] va [5] = '{16'h1234, 16'h8000, 16'h8000, 16'h12A4, 16'hFFFE};
      logic [15:0] vb [5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h12A5, 16'hFFFD};
      bit          vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  vo [5] = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b100};
      int          vl [5] = '{4, 1, 1, 4, 4};
      logic [2:0]  got;
      int          lat;
      bit          i_ok, b_ok, s_ok, p_ok;
      for (int i = 0; i < 5; i++) begin
         run_txn(va[i], vb[i], vs[i], 0, 1'b0, got, lat, i_ok, b_ok, s_ok, p_ok);
         n_cmp++;
         if (got !== vo[i]) begin
            n_fail++; $display("FAIL directed_out[%0d] got=%b exp=%b", i, got, vo[i]);
         end
         n_cmp++;
         if (lat !== vl[i]) begin
            n_fail++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, vl[i]);
         end
         n_cmp++;
         if ({i_ok, b_ok, p_ok} !== 3'b111) begin
            n_fail++;
            $display("FAIL directed_ready[%0d] got idle/busy/post=%b%b%b exp=111",
                     i, i_ok, b_ok, p_ok);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2:0] got;
      int         lat;
      bit         i_ok, b_ok, s_ok, p_ok;
      run_txn(16'h00F0, 16'h0100, 1'b0, 3, 1'b0, got, lat, i_ok, b_ok, s_ok, p_ok);
      n_cmp++;
      if (got !== 3'b001 || lat !== 2) begin
         n_fail++; $display("FAIL bp_result got=%b/%0d exp=001/2", got, lat);
      end
      n_cmp++;
      if (s_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable got=%b exp=1", s_ok);
      end
      n_cmp++;
      if (p_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_release got=%b exp=1", p_ok);
      end
      // Accept on the very edge after the release handshake.
      run_txn(16'hA5A5, 16'hA5A5, 1'b1, 0, 1'b0, got, lat, i_ok, b_ok, s_ok, p_ok);
      n_cmp++;
      if (got !== 3'b010 || lat !== 4 || i_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_next got=%b/%0d/%b exp=010/4/1", got, lat, i_ok);
      end
   endtask

   task automatic test_early_ready();
      logic [2:0] got;
      int         lat;
      bit         i_ok, b_ok, s_ok, p_ok;
      run_txn(16'h8000, 16'h0000, 1'b1, 0, 1'b1, got, lat, i_ok, b_ok, s_ok, p_ok);
      n_cmp++;
      if (got !== 3'b001 || lat !== 1 || p_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL early_ready got=%b/%0d/%b exp=001/1/1", got, lat, p_ok);
      end
   endtask

   task automatic test_reset_abort();
      logic [2:0] got;
      int         lat;
      bit         i_ok, b_ok, s_ok, p_ok;
      bit         quiet;
      bus.a          = 16'h1234;
      bus.b          = 16'h1234;
      bus.signed_cmp = 1'b0;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_outputs got=%b/%b exp=0/000", bus.out_valid, bus.out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 1'b0;
      end
      n_cmp++;
      if (quiet !== 1'b1) begin
         n_fail++; $display("FAIL abort_no_stale got=%b exp=1", quiet);
      end
      run_txn(16'h0001, 16'h0000, 1'b0, 0, 1'b0, got, lat, i_ok, b_ok, s_ok, p_ok);
      n_cmp++;
      if (got !== 3'b100 || lat !== 4) begin
         n_fail++; $display("FAIL abort_next got=%b/%0d exp=100/4", got, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] ra, rb;
      bit          sg;
      logic [2:0]  got, exp_o;
      int          lat, exp_l;
      bit          i_ok, b_ok, s_ok, p_ok;
      for (int n = 0; n < 3000; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(2))
            0:       rb = 16'($urandom);
            1:       rb = ra;
            default: rb = ra ^ (16'h0001 << $urandom_range(15));
         endcase
         sg    = 1'($urandom);
         exp_o = ref_cmp(ra, rb, sg);
         exp_l = ref_lat(ra, rb);
         run_txn(ra, rb, sg, ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0,
                 ($urandom_range(7) == 0), got, lat, i_ok, b_ok, s_ok, p_ok);
         n_cmp++;
         if (got !== exp_o || $countones(got) != 1) begin
            n_fail++;
            $display("FAIL rand_out a=%h b=%h s=%b got=%b exp=%b", ra, rb, sg, got, exp_o);
         end
         n_cmp++;
         if (lat !== exp_l) begin
            n_fail++;
            $display("FAIL rand_lat a=%h b=%h got=%0d exp=%0d", ra, rb, lat, exp_l);
         end
         n_cmp++;
         if ({i_ok, b_ok, s_ok, p_ok} !== 4'b1111) begin
            n_fail++;
            $display("FAIL rand_handshake a=%h b=%h got=%b%b%b%b exp=1111",
                     ra, rb, i_ok, b_ok, s_ok, p_ok);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_early_ready();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
